// File: rtl/exception_ctrl.sv
// MEM-stage exception resolver: detects interrupts/exceptions/eret, issues a one-cycle
// registered flush with redirect PC and CP0 update values, then masks new exceptions while draining.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_excepttype_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] excepttype_o,
  output logic        cp0_exc_we_o,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] cp0_cause_o,
  output logic [31:0] cp0_status_o
);

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StDrain
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [2:0]  r_drain_cnt;
  logic [2:0]  w_drain_cnt_d;

  logic [31:0] w_eff_status;
  logic [31:0] w_eff_cause;
  logic [31:0] w_eff_epc;
  logic        w_int_pending;
  logic [31:0] w_code;
  logic [4:0]  w_exccode;
  logic        w_is_eret;
  logic        w_detect;
  logic [31:0] w_npc_val;
  logic [31:0] w_epc_val;
  logic [31:0] w_cause_val;
  logic [31:0] w_status_val;

  logic        r_flush;
  logic        r_exc_we;
  logic [31:0] r_new_pc;
  logic [31:0] r_excepttype;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_status;

  logic        w_unused_exc;
  assign w_unused_exc = ^{mem_excepttype_i[31:13], mem_excepttype_i[7:0]};

  // Forward a same-cycle WB write; only the software-writable cause bits are taken.
  always_comb begin
    w_eff_status = cp0_status_i;
    w_eff_cause  = cp0_cause_i;
    w_eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == CP0_STATUS) w_eff_status = wb_cp0_wdata_i;
      if (wb_cp0_waddr_i == CP0_EPC)    w_eff_epc    = wb_cp0_wdata_i;
      if (wb_cp0_waddr_i == CP0_CAUSE) begin
        w_eff_cause[9:8] = wb_cp0_wdata_i[9:8];
        w_eff_cause[22]  = wb_cp0_wdata_i[22];
        w_eff_cause[23]  = wb_cp0_wdata_i[23];
      end
    end
  end

  assign w_int_pending = ((w_eff_cause[15:8] & w_eff_status[15:8]) != 8'h00) &&
                         !w_eff_status[1] && w_eff_status[0];

  always_comb begin
    w_code    = 32'd0;
    w_exccode = 5'd0;
    if (w_int_pending) begin
      w_code    = 32'd1;
      w_exccode = 5'd0;
    end else if (mem_excepttype_i[8]) begin
      w_code    = 32'd8;
      w_exccode = 5'd8;
    end else if (mem_excepttype_i[9]) begin
      w_code    = 32'd10;
      w_exccode = 5'd10;
    end else if (mem_excepttype_i[10]) begin
      w_code    = 32'd13;
      w_exccode = 5'd13;
    end else if (mem_excepttype_i[11]) begin
      w_code    = 32'd12;
      w_exccode = 5'd12;
    end else if (mem_excepttype_i[12]) begin
      w_code    = 32'd14;
      w_exccode = 5'd14;
    end
  end

  assign w_is_eret = (w_code == 32'd14);
  assign w_detect  = (r_state == StIdle) && mem_valid_i && (w_code != 32'd0);

  // With EXL already set, a nested exception keeps the original EPC and BD bit.
  always_comb begin
    w_npc_val    = EXC_VECTOR;
    w_epc_val    = w_eff_epc;
    w_cause_val  = w_eff_cause;
    w_status_val = w_eff_status;
    if (w_is_eret) begin
      w_npc_val       = w_eff_epc;
      w_status_val[1] = 1'b0;
    end else begin
      w_status_val[1]  = 1'b1;
      w_cause_val[6:2] = w_exccode;
      if (!w_eff_status[1]) begin
        w_epc_val       = mem_in_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
        w_cause_val[31] = mem_in_delayslot_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_drain_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_d;
      r_drain_cnt <= w_drain_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_drain_cnt_d = r_drain_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_detect) w_state_d = StFlush;
      end
      StFlush: begin
        w_state_d     = StDrain;
        w_drain_cnt_d = DRAIN_LAST;
      end
      StDrain: begin
        if (r_drain_cnt == 3'd0) begin
          w_state_d = StIdle;
        end else begin
          w_drain_cnt_d = r_drain_cnt - 3'd1;
        end
      end
      default: begin
        w_state_d     = StIdle;
        w_drain_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush      <= 1'b0;
      r_exc_we     <= 1'b0;
      r_excepttype <= 32'd0;
      r_new_pc     <= 32'd0;
      r_epc        <= 32'd0;
      r_cause      <= 32'd0;
      r_status     <= 32'd0;
    end else if (w_detect) begin
      r_flush      <= 1'b1;
      r_exc_we     <= 1'b1;
      r_excepttype <= w_code;
      r_new_pc     <= w_npc_val;
      r_epc        <= w_epc_val;
      r_cause      <= w_cause_val;
      r_status     <= w_status_val;
    end else begin
      r_flush      <= 1'b0;
      r_exc_we     <= 1'b0;
      r_excepttype <= 32'd0;
    end
  end

  assign flush_o      = r_flush;
  assign cp0_exc_we_o = r_exc_we;
  assign excepttype_o = r_excepttype;
  assign new_pc_o     = r_new_pc;
  assign cp0_epc_o    = r_epc;
  assign cp0_cause_o  = r_cause;
  assign cp0_status_o = r_status;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed + randomized bench for exception_ctrl against a cycle-level reference model.
module tb_exception_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_0020;
  localparam int          D       = 2;

  logic        clk;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mem_excepttype_i;
  logic        mem_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] excepttype_o;
  logic        cp0_exc_we_o;
  logic [31:0] cp0_epc_o;
  logic [31:0] cp0_cause_o;
  logic [31:0] cp0_status_o;

  exception_ctrl #(.EXC_VECTOR(EXC_VEC), .DRAIN_CYCLES(D)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_valid_i       (mem_valid_i),
    .mem_pc_i          (mem_pc_i),
    .mem_excepttype_i  (mem_excepttype_i),
    .mem_in_delayslot_i(mem_in_delayslot_i),
    .cp0_status_i      (cp0_status_i),
    .cp0_cause_i       (cp0_cause_i),
    .cp0_epc_i         (cp0_epc_i),
    .wb_cp0_we_i       (wb_cp0_we_i),
    .wb_cp0_waddr_i    (wb_cp0_waddr_i),
    .wb_cp0_wdata_i    (wb_cp0_wdata_i),
    .flush_o           (flush_o),
    .new_pc_o          (new_pc_o),
    .excepttype_o      (excepttype_o),
    .cp0_exc_we_o      (cp0_exc_we_o),
    .cp0_epc_o         (cp0_epc_o),
    .cp0_cause_o       (cp0_cause_o),
    .cp0_status_o      (cp0_status_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: expected outputs plus number of upcoming edges that ignore exceptions.
  logic        m_flush, m_we;
  logic [31:0] m_npc, m_exc, m_epc, m_cause, m_status;
  int          m_block;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] s, c, e, code;
    logic        intp;
    if (rst) begin
      m_flush = 0; m_we = 0; m_npc = 0; m_exc = 0; m_epc = 0; m_cause = 0; m_status = 0;
      m_block = 0;
    end else if (m_block > 0) begin
      m_block--;
      m_flush = 0; m_we = 0; m_exc = 0;
    end else begin
      s = cp0_status_i; c = cp0_cause_i; e = cp0_epc_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) s = wb_cp0_wdata_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) e = wb_cp0_wdata_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13)
        c = (c & ~32'h00C0_0300) | (wb_cp0_wdata_i & 32'h00C0_0300);
      intp = ((c[15:8] & s[15:8]) != 0) && !s[1] && s[0];
      if (intp)                     code = 1;
      else if (mem_excepttype_i[8])  code = 8;
      else if (mem_excepttype_i[9])  code = 10;
      else if (mem_excepttype_i[10]) code = 13;
      else if (mem_excepttype_i[11]) code = 12;
      else if (mem_excepttype_i[12]) code = 14;
      else                           code = 0;
      if (mem_valid_i && code != 0) begin
        m_flush = 1; m_we = 1; m_exc = code; m_block = 1 + D;
        if (code == 14) begin
          m_npc = e; m_epc = e; m_cause = c; m_status = s & ~32'h2;
        end else begin
          m_npc    = EXC_VEC;
          m_status = s | 32'h2;
          m_cause  = c;
          m_cause[6:2] = (code == 1) ? 5'd0 : code[4:0];
          if (s[1]) begin
            m_epc = e;
          end else begin
            m_epc = mem_in_delayslot_i ? mem_pc_i - 32'd4 : mem_pc_i;
            m_cause[31] = mem_in_delayslot_i;
          end
        end
      end else begin
        m_flush = 0; m_we = 0; m_exc = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("flush", {31'd0, flush_o}, {31'd0, m_flush});
    chk("exc_we", {31'd0, cp0_exc_we_o}, {31'd0, m_we});
    chk("new_pc", new_pc_o, m_npc);
    chk("excepttype", excepttype_o, m_exc);
    chk("epc", cp0_epc_o, m_epc);
    chk("cause", cp0_cause_o, m_cause);
    chk("status", cp0_status_o, m_status);
  endtask

  task automatic idle();
    rst = 0; mem_valid_i = 0; mem_pc_i = 0; mem_excepttype_i = 0; mem_in_delayslot_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_wdata_i = 0;
  endtask

  task automatic exc(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                     input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
    idle();
    mem_valid_i = 1; mem_excepttype_i = et; mem_pc_i = pc; mem_in_delayslot_i = ds;
    cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = ep;
  endtask

  task automatic rand_inputs();
    logic [31:0] v;
    rst                = ($urandom_range(63) == 0);
    mem_valid_i        = ($urandom_range(3) != 0);
    mem_pc_i           = ($urandom_range(15) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
    mem_in_delayslot_i = $urandom_range(1);
    v = $urandom & ~32'h0000_1F00;
    if ($urandom_range(2) != 0) v = v | (($urandom_range(31) << 8) & 32'h0000_1F00);
    mem_excepttype_i = v;
    v = $urandom;
    v[0] = ($urandom_range(3) != 0);
    v[1] = $urandom_range(1);
    cp0_status_i   = v;
    cp0_cause_i    = $urandom;
    cp0_epc_i      = $urandom;
    wb_cp0_we_i    = $urandom_range(1);
    case ($urandom_range(3))
      0: wb_cp0_waddr_i = 5'd12;
      1: wb_cp0_waddr_i = 5'd13;
      2: wb_cp0_waddr_i = 5'd14;
      default: wb_cp0_waddr_i = 5'($urandom);
    endcase
    wb_cp0_wdata_i = $urandom;
  endtask

  initial begin
    int nflush;
    m_flush = 0; m_we = 0; m_npc = 0; m_exc = 0; m_epc = 0; m_cause = 0; m_status = 0;
    m_block = 0;
    idle();
    rst = 1;
    cyc(); cyc();
    chk("reset_new_pc", new_pc_o, 32'd0);
    rst = 0;
    cyc();

    // Syscall, no delay slot
    exc(32'h100, 32'h100, 0, 32'h1000_0001, 32'h0, 32'h0);
    cyc();
    chk("sys_flush", {31'd0, flush_o}, 32'd1);
    chk("sys_npc", new_pc_o, 32'h20);
    chk("sys_code", excepttype_o, 32'd8);
    chk("sys_epc", cp0_epc_o, 32'h100);
    chk("sys_exccode", {27'd0, cp0_cause_o[6:2]}, 32'd8);
    chk("sys_status", cp0_status_o, 32'h1000_0003);
    idle(); repeat (D + 2) cyc();
    chk("hold_npc", new_pc_o, 32'h20);

    // Overflow in delay slot
    exc(32'h800, 32'h204, 1, 32'h0000_0001, 32'h0, 32'h0);
    cyc();
    chk("ov_epc", cp0_epc_o, 32'h200);
    chk("ov_bd", {31'd0, cp0_cause_o[31]}, 32'd1);
    chk("ov_exccode", {27'd0, cp0_cause_o[6:2]}, 32'd12);
    idle(); repeat (D + 2) cyc();

    // Interrupt beats syscall; with EXL set the syscall wins
    exc(32'h100, 32'h400, 0, 32'h0000_0401, 32'h0000_0400, 32'h0);
    cyc();
    chk("int_code", excepttype_o, 32'd1);
    idle(); repeat (D + 2) cyc();
    exc(32'h100, 32'h400, 0, 32'h0000_0403, 32'h0000_0400, 32'h44);
    cyc();
    chk("exl_code", excepttype_o, 32'd8);
    chk("exl_epc", cp0_epc_o, 32'h44);
    idle(); repeat (D + 2) cyc();

    // Eret with forwarded EPC
    exc(32'h1000, 32'h500, 0, 32'h0000_0003, 32'h0, 32'h80);
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h300;
    cyc();
    chk("eret_npc", new_pc_o, 32'h300);
    chk("eret_exl", {31'd0, cp0_status_o[1]}, 32'd0);
    idle(); repeat (D + 2) cyc();

    // Back-to-back syscalls: one pulse, masked window, then accepted again
    exc(32'h100, 32'h600, 0, 32'h0000_0001, 32'h0, 32'h0);
    cyc();
    chk("b2b_first", {31'd0, flush_o}, 32'd1);
    nflush = 0;
    for (int i = 0; i < D + 1; i++) begin
      cyc();
      nflush += int'(flush_o);
    end
    chk("b2b_masked", nflush, 32'd0);
    cyc();
    chk("b2b_third", {31'd0, flush_o}, 32'd1);
    idle(); repeat (D + 2) cyc();

    // Reset during drain aborts; next exception accepted immediately
    exc(32'h200, 32'h700, 0, 32'h0000_0001, 32'h0, 32'h0);
    cyc(); cyc();
    idle(); rst = 1;
    cyc();
    chk("rst_epc", cp0_epc_o, 32'd0);
    chk("rst_code", excepttype_o, 32'd0);
    exc(32'h400, 32'h708, 0, 32'h0000_0001, 32'h0, 32'h0);
    cyc();
    chk("rst_next", excepttype_o, 32'd13);
    idle(); repeat (D + 2) cyc();

    // PC wrap in delay slot
    exc(32'h100, 32'h0, 1, 32'h0000_0001, 32'h0, 32'h0);
    cyc();
    chk("wrap_epc", cp0_epc_o, 32'hFFFF_FFFC);
    idle(); repeat (D + 2) cyc();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020, is the exception handler entry address.
REQ-002 Parameter DRAIN_CYCLES, default 2, is the number of cycles new exceptions are masked after a flush (range 1-7).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_valid_i  input  1  MEM-stage instruction valid.
REQ-006 mem_pc_i  input  32  MEM-stage instruction PC.
REQ-007 mem_excepttype_i  input  32  exception flags: bit8 syscall, bit9 invalid instr, bit10 trap, bit11 overflow, bit12 eret.
REQ-008 mem_in_delayslot_i  input  1  MEM instruction is in a branch delay slot.
REQ-009 cp0_status_i / cp0_cause_i / cp0_epc_i  input  32 each  current CP0 register values.
REQ-010 wb_cp0_we_i, wb_cp0_waddr_i[4:0], wb_cp0_wdata_i[31:0]  input  pending WB-stage CP0 write, for forwarding.
REQ-011 flush_o  output  1  pipeline flush pulse.
REQ-012 new_pc_o  output  32  redirect target, valid while flush_o=1.
REQ-013 excepttype_o  output  32  resolved code: 1 int, 8 sys, 10 invalid, 13 trap, 12 ov, 14 eret, 0 none.
REQ-014 cp0_exc_we_o  output  1  one-cycle strobe to update CP0 EPC/Cause/Status.
REQ-015 cp0_epc_o / cp0_cause_o / cp0_status_o  output  32 each  values CP0 loads when cp0_exc_we_o=1.

Function
REQ-016 The block SHALL form effective status/cause/epc by substituting wb_cp0_wdata_i when wb_cp0_we_i=1 and wb_cp0_waddr_i addresses that register (12/13/14); cause forwarding SHALL replace only bits 9:8, 22, 23.
REQ-017 Interrupt pending SHALL be (eff_cause[15:8] & eff_status[15:8]) != 0 AND eff_status[1]=0 AND eff_status[0]=1.
REQ-018 Detection SHALL occur only when mem_valid_i=1 and state is IDLE; priority: interrupt > syscall > invalid > trap > overflow > eret.
REQ-019 FSM states: IDLE, FLUSH, DRAIN; IDLE->FLUSH on detection; FLUSH->DRAIN after exactly 1 cycle; DRAIN->IDLE after DRAIN_CYCLES cycles.
REQ-020 Latency: flush_o, cp0_exc_we_o, new_pc_o, excepttype_o SHALL be registered, asserted the cycle after detection, for exactly one cycle (FLUSH state).
REQ-021 Non-eret: new_pc_o=EXC_VECTOR; cp0_epc_o=mem_pc_i-4 if in delay slot else mem_pc_i; cp0_cause_o=eff_cause with bit31=mem_in_delayslot_i and bits 6:2=ExcCode; cp0_status_o=eff_status with bit1=1.
REQ-022 If eff_status[1]=1 at a non-eret, non-interrupt exception, cp0_epc_o and cause bit31 SHALL retain eff_epc/eff_cause[31] (no EPC overwrite).
REQ-023 Eret: new_pc_o=eff_epc (forwarded); cp0_status_o=eff_status with bit1=0; cp0_epc_o=eff_epc; cp0_cause_o=eff_cause.
REQ-024 Outside FLUSH, flush_o=0, cp0_exc_we_o=0, excepttype_o=0; new_pc_o and cp0_*_o SHALL hold last values.
REQ-025 Exceptions presented during FLUSH or DRAIN SHALL be ignored (squashed instructions).
REQ-026 PC arithmetic SHALL be 32-bit modulo; mem_pc_i=0 in delay slot gives EPC 32'hFFFF_FFFC.

Reset
REQ-027 rst=1 SHALL force state IDLE, drain counter 0, flush_o=0, cp0_exc_we_o=0, excepttype_o=0, new_pc_o=0, cp0_epc_o=0, cp0_cause_o=0, cp0_status_o=0.
REQ-028 rst asserted in FLUSH or DRAIN SHALL abort the sequence; next edge after rst deasserts may detect a new exception.

Verification
REQ-029 syscall bit8, pc=32'h100, no delay slot, status=32'h1000_0001 -> next cycle flush_o=1, new_pc_o=32'h20, excepttype_o=8, cp0_epc_o=32'h100, cp0_cause_o[6:2]=8, cp0_status_o=32'h1000_0003.
REQ-030 overflow, pc=32'h204, delayslot=1 -> cp0_epc_o=32'h200, cp0_cause_o[31]=1, ExcCode 12.
REQ-031 status=32'h0000_0401, cause[10]=1, plus syscall -> excepttype_o=1 (interrupt wins); same with status[1]=1 -> syscall taken instead.
REQ-032 eret with epc=32'h80, WB writing EPC=32'h300 same cycle -> new_pc_o=32'h300, cp0_status_o[1]=0.
REQ-033 Two back-to-back syscalls -> single flush_o pulse; second ignored; third presented after DRAIN_CYCLES+1 cycles flushes.
REQ-034 rst during DRAIN -> outputs all zero, state IDLE, next exception accepted immediately.
